// File: rtl/wb_dec_to_if.sv
// Wishbone decoder bus bundle.
//   Master side : stb_i, adr_i (request), ack_o, err_o, dat_o (response).
//   Slave fan-out: slv_stb_o (one-hot strobes), slv_ack_i, slv_dat_i (packed, slave i at [i*DW +: DW]).
// Signal names take the decoder's point of view, so _i/_o are relative to wb_dec_to.
interface wb_dec_to_if #(
  parameter int unsigned SLAVES = 16,
  parameter int unsigned SW     = (SLAVES > 1) ? $clog2(SLAVES) : 1,
  parameter int unsigned DW     = 32
);
  logic                   stb_i;
  logic [SW-1:0]          adr_i;
  logic                   ack_o;
  logic                   err_o;
  logic [DW-1:0]          dat_o;
  logic [SLAVES-1:0]      slv_stb_o;
  logic [SLAVES-1:0]      slv_ack_i;
  logic [SLAVES*DW-1:0]   slv_dat_i;

  // Decoder side.
  modport slave (
    input  stb_i, adr_i, slv_ack_i, slv_dat_i,
    output ack_o, err_o, dat_o, slv_stb_o
  );

  // Bus-master side.
  modport master (
    output stb_i, adr_i,
    input  ack_o, err_o, dat_o
  );
endinterface

// File: rtl/wb_dec_to.sv
// Registered Wishbone slave-select decoder with a per-transaction watchdog.
// The slave index is latched when a transaction starts; only that slave is strobed and its
// ack/data come back through registered outputs. Unmapped indices and slaves that do not ack
// within TIMEOUT cycles produce a one-cycle err_o pulse, so the bus can never hang.
// Ports:
//   clk_i : clock
//   rst_i : synchronous, active-high reset
//   bus   : wb_dec_to_if.slave (stb_i/adr_i in, ack_o/err_o/dat_o out,
//           slv_stb_o out, slv_ack_i/slv_dat_i in)
module wb_dec_to #(
  parameter int unsigned SLAVES  = 16,
  parameter int unsigned SW      = (SLAVES > 1) ? $clog2(SLAVES) : 1,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_dec_to_if.slave      bus
);

  // Counter only has to reach TIMEOUT-1; keep at least one bit when the watchdog is off.
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DW-1:0]     dat_q, dat_d;
  logic [SLAVES-1:0] slv_stb_q, slv_stb_d;

  logic              adr_mapped;
  logic [SLAVES-1:0] adr_onehot;
  logic              sel_ack;
  logic [DW-1:0]     sel_dat;
  logic              timeout_hit;

  // Decode of the live request index. Zero-extended so an SW wider than needed still
  // compares correctly against SLAVES.
  always_comb begin
    adr_mapped = (32'(bus.adr_i) < SLAVES);
    adr_onehot = '0;
    for (int unsigned i = 0; i < SLAVES; i++) begin
      adr_onehot[i] = (32'(bus.adr_i) == i);
    end
  end

  // Mux of the latched slave's ack/data; acks from every other slave are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int unsigned i = 0; i < SLAVES; i++) begin
      if (32'(sel_q) == i) begin
        sel_ack = bus.slv_ack_i[i];
        sel_dat = bus.slv_dat_i[i*DW +: DW];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == (TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = dat_q;
    slv_stb_d = slv_stb_q;

    unique case (state_q)
      StIdle: begin
        slv_stb_d = '0;
        if (bus.stb_i) begin
          if (adr_mapped) begin
            sel_d     = bus.adr_i;
            cnt_d     = '0;
            slv_stb_d = adr_onehot;
            state_d   = StBusy;
          end else begin
            err_d   = 1'b1;
            dat_d   = '0;
            state_d = StResp;
          end
        end
      end

      StBusy: begin
        if (!bus.stb_i) begin
          // Master abort: silently release the slave.
          slv_stb_d = '0;
          state_d   = StIdle;
        end else if (sel_ack) begin
          // Ack beats a watchdog expiry in the same cycle.
          ack_d     = 1'b1;
          dat_d     = sel_dat;
          slv_stb_d = '0;
          state_d   = StResp;
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          dat_d     = '0;
          slv_stb_d = '0;
          state_d   = StResp;
        end else if (cnt_q != '1) begin
          // Saturate rather than wrap (only reachable with the watchdog disabled).
          cnt_d = cnt_q + CW'(1);
        end
      end

      StResp: begin
        // One-cycle response pulse; stb_i is deliberately not sampled here.
        slv_stb_d = '0;
        state_d   = StIdle;
      end

      default: begin
        slv_stb_d = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      slv_stb_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      slv_stb_q <= slv_stb_d;
    end
  end

  assign bus.ack_o     = ack_q;
  assign bus.err_o     = err_q;
  assign bus.dat_o     = dat_q;
  assign bus.slv_stb_o = slv_stb_q;

endmodule
